// File: rtl/jump_sound_synth.sv
// Jump chirp generator: a square wave that rises in pitch and decays in amplitude note by note.
// Each sample is shifted out MSB first to an SPI DAC as the 16-bit word {4'b0011, sample}.
module jump_sound_synth #(
  parameter int          SAMPLE_DIV   = 400,
  parameter int          SCK_DIV      = 4,
  parameter int          TONE_START   = 20,
  parameter int          TONE_STEP    = 4,
  parameter int          NOTE_SAMPLES = 200,
  parameter int          NUM_NOTES    = 4,
  parameter logic [11:0] AMP_INIT     = 12'h400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic        busy,
  output logic [11:0] sample_out,
  output logic        dac_sdi,
  output logic        dac_cs,
  output logic        dac_sck
);

  localparam int DATA_W = 12;

  typedef enum logic [1:0] {IDLE, PLAY, FLUSH} state_t;

  state_t state, state_nxt;
  logic [15:0] div_cnt, note, smp_cnt, phase;
  logic        pol, flush_sent;
  logic        launch_vld_p0;
  logic        frame_act;
  logic [15:0] shreg;
  logic [15:0] sck_cnt;
  logic [3:0]  bit_cnt;

  logic              tick, ser_busy, last_smp, last_note, sck_edge, frame_done, launch;
  logic [DATA_W-1:0] amp, smp_val;
  logic [15:0]       hp, word;

  function automatic logic [15:0] half_period(input logic [15:0] n);
    int h;
    h = TONE_START - int'(n) * TONE_STEP;
    if (h < 1) h = 1;
    return 16'(h);
  endfunction

  // Mid-scale offset plus or minus the amplitude, clamped to the DAC code range.
  function automatic logic [DATA_W-1:0] sat_sample(input logic p, input logic [DATA_W-1:0] a);
    logic signed [13:0] v;
    v = p ? (14'sh800 + $signed({2'b00, a})) : (14'sh800 - $signed({2'b00, a}));
    if (v < 0) return 12'h000;
    else if (v > 14'sh0FFF) return 12'hFFF;
    else return v[11:0];
  endfunction

  assign tick       = (state != IDLE) && (div_cnt == '0);
  assign ser_busy   = launch_vld_p0 || frame_act;
  assign last_smp   = (smp_cnt == 16'(NOTE_SAMPLES - 1));
  assign last_note  = (note == 16'(NUM_NOTES - 1));
  assign sck_edge   = (sck_cnt == 16'(SCK_DIV - 1));
  assign frame_done = frame_act && sck_edge && dac_sck && (bit_cnt == 4'd15);
  assign hp         = half_period(note);
  assign amp        = AMP_INIT >> note;
  assign smp_val    = (state == PLAY) ? sat_sample(pol, amp) : 12'h800;
  assign launch     = tick && !ser_busy && !trigger && ((state == PLAY) || !flush_sent);
  assign word       = {4'b0011, sample_out};
  assign busy       = (state != IDLE) || ser_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = PLAY;
      PLAY:    if (trigger) state_nxt = PLAY;
               else if (tick && last_smp && last_note) state_nxt = FLUSH;
      FLUSH:   if (trigger) state_nxt = PLAY;
               else if (flush_sent && frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: tone generation and sample tick
  always_ff @(posedge clk) begin
    if (rst || trigger) begin
      div_cnt    <= '0;
      note       <= '0;
      smp_cnt    <= '0;
      phase      <= '0;
      pol        <= 1'b1;
      flush_sent <= 1'b0;
    end else if (state != IDLE) begin
      div_cnt <= (div_cnt == 16'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 16'd1;
      if (tick && state == PLAY) begin
        if (last_smp) begin
          smp_cnt <= '0;
          note    <= note + 16'd1;
          phase   <= '0;
          pol     <= 1'b1;
        end else begin
          smp_cnt <= smp_cnt + 16'd1;
          if (phase == hp - 16'd1) begin
            phase <= '0;
            pol   <= ~pol;
          end else begin
            phase <= phase + 16'd1;
          end
        end
      end
      if (launch && state == FLUSH) flush_sent <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out    <= 12'h800;
      launch_vld_p0 <= 1'b0;
    end else begin
      launch_vld_p0 <= launch;
      if (launch) sample_out <= smp_val;
    end
  end

  // Stage p1: SPI serializer; the next bit is presented on each falling sck
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_act <= 1'b0;
      dac_cs    <= 1'b1;
      dac_sck   <= 1'b0;
      dac_sdi   <= 1'b0;
      sck_cnt   <= '0;
      bit_cnt   <= '0;
    end else if (launch_vld_p0) begin
      frame_act <= 1'b1;
      dac_cs    <= 1'b0;
      dac_sck   <= 1'b0;
      dac_sdi   <= word[15];
      sck_cnt   <= '0;
      bit_cnt   <= '0;
    end else if (frame_act) begin
      if (sck_edge) begin
        sck_cnt <= '0;
        dac_sck <= ~dac_sck;
        if (dac_sck) begin
          if (bit_cnt == 4'd15) begin
            dac_cs    <= 1'b1;
            frame_act <= 1'b0;
            dac_sdi   <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            dac_sdi <= shreg[15];
          end
        end
      end else begin
        sck_cnt <= sck_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (launch_vld_p0) shreg <= {word[14:0], 1'b0};
    else if (frame_act && sck_edge && dac_sck) shreg <= {shreg[14:0], 1'b0};
  end

endmodule

// File: tb/tb_jump_sound_synth.sv
// Bench for jump_sound_synth: decodes every SPI frame from two instances and
// compares each against a queue of expected samples built from a segment table.
module tb_jump_sound_synth;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger = 1'b0, trigger2 = 1'b0;
  logic busy, busy2, sdi, sdi2, cs, cs2, sck, sck2;
  logic [11:0] sample_out, sample_out2;

  always #5 clk = ~clk;

  jump_sound_synth #(.SAMPLE_DIV(40), .SCK_DIV(1), .TONE_START(4), .TONE_STEP(1),
                     .NOTE_SAMPLES(8), .NUM_NOTES(3), .AMP_INIT(12'h400)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .busy(busy), .sample_out(sample_out),
    .dac_sdi(sdi), .dac_cs(cs), .dac_sck(sck));

  jump_sound_synth #(.SAMPLE_DIV(40), .SCK_DIV(1), .TONE_START(2), .TONE_STEP(3),
                     .NOTE_SAMPLES(8), .NUM_NOTES(3), .AMP_INIT(12'hFFF)) dut2 (
    .clk(clk), .rst(rst), .trigger(trigger2), .busy(busy2), .sample_out(sample_out2),
    .dac_sdi(sdi2), .dac_cs(cs2), .dac_sck(sck2));

  int vectors = 0;
  int errors  = 0;

  typedef struct { int unit; logic [11:0] smp; int reps; } seg_t;
  seg_t segs[$];

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  int          frames[2] = '{0, 0};
  int          nbits[2]  = '{0, 0};
  int          lowcnt[2] = '{0, 0};
  logic [15:0] sh[2];
  logic        pcs[2]    = '{1'b1, 1'b1};
  logic        psck[2]   = '{1'b0, 1'b0};
  logic        psdi[2]   = '{1'b0, 1'b0};
  logic        sdi_bad[2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_seq(input int unit);
    for (int s = 0; s < segs.size(); s++)
      if (segs[s].unit == unit)
        for (int r = 0; r < segs[s].reps; r++)
          if (unit == 0) q0.push_back({4'b0011, segs[s].smp});
          else           q1.push_back({4'b0011, segs[s].smp});
  endtask

  task automatic mon_step(input int i, input logic c, input logic k, input logic d);
    logic [15:0] e;
    if (rst) begin
      nbits[i] = 0; lowcnt[i] = 0; sdi_bad[i] = 1'b0;
      pcs[i] = 1'b1; psck[i] = 1'b0; psdi[i] = 1'b0;
      return;
    end
    if (!c) begin
      lowcnt[i]++;
      if (k && !psck[i]) begin
        sh[i] = {sh[i][14:0], d};
        nbits[i]++;
      end
      if (k && (d !== psdi[i])) sdi_bad[i] = 1'b1;
    end
    if (c && !pcs[i]) begin
      frames[i]++;
      if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        vectors++; errors++;
        $display("FAIL frame_unexpected dut%0d: got word %h, expected no frame", i, sh[i]);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("frame_word dut%0d #%0d", i, frames[i]), {16'd0, sh[i]}, {16'd0, e});
      end
      chk($sformatf("frame_bits dut%0d", i), nbits[i], 32'd16);
      chk($sformatf("cs_low_clocks dut%0d", i), lowcnt[i], 32'd32);
      chk($sformatf("sdi_stable_sck_high dut%0d", i), {31'd0, sdi_bad[i]}, 32'd0);
      nbits[i] = 0; lowcnt[i] = 0; sdi_bad[i] = 1'b0;
    end
    pcs[i] = c; psck[i] = k; psdi[i] = d;
  endtask

  always @(negedge clk) begin
    mon_step(0, cs, sck, sdi);
    mon_step(1, cs2, sck2, sdi2);
  end

  task automatic wait_idle(input int unit, input string name);
    logic prev_cs;
    int   n;
    prev_cs = (unit == 0) ? cs : cs2;
    n = 0;
    while (((unit == 0) ? busy : busy2) && n < 3000) begin
      prev_cs = (unit == 0) ? cs : cs2;
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      vectors++; errors++;
      $display("FAIL %s timeout: busy still 1 after %0d clocks, required 0", name, n);
    end else begin
      chk({name, " busy_falls_with_cs_rise"}, {prev_cs, (unit == 0) ? cs : cs2}, 32'b01);
    end
    @(negedge clk);
  endtask

  task automatic pulse(input int unit);
    @(negedge clk);
    if (unit == 0) trigger = 1'b1; else trigger2 = 1'b1;
    @(negedge clk);
    trigger = 1'b0; trigger2 = 1'b0;
  endtask

  initial begin
    int base, n;
    segs = '{
      '{0, 12'hC00, 4}, '{0, 12'h400, 4},
      '{0, 12'hA00, 3}, '{0, 12'h600, 3}, '{0, 12'hA00, 2},
      '{0, 12'h900, 2}, '{0, 12'h700, 2}, '{0, 12'h900, 2}, '{0, 12'h700, 2},
      '{0, 12'h800, 1},
      '{1, 12'hFFF, 2}, '{1, 12'h000, 2}, '{1, 12'hFFF, 2}, '{1, 12'h000, 2},
      '{1, 12'hFFF, 1}, '{1, 12'h001, 1}, '{1, 12'hFFF, 1}, '{1, 12'h001, 1},
      '{1, 12'hFFF, 1}, '{1, 12'h001, 1}, '{1, 12'hFFF, 1}, '{1, 12'h001, 1},
      '{1, 12'hBFF, 1}, '{1, 12'h401, 1}, '{1, 12'hBFF, 1}, '{1, 12'h401, 1},
      '{1, 12'hBFF, 1}, '{1, 12'h401, 1}, '{1, 12'hBFF, 1}, '{1, 12'h401, 1},
      '{1, 12'h800, 1}};

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset outputs", {busy, cs, sck, sdi, sample_out}, {4'b0100, 12'h800});
    repeat (200) @(negedge clk);
    chk("idle outputs", {busy, cs, sck, sdi, sample_out}, {4'b0100, 12'h800});
    chk("idle frames", frames[0] + frames[1], 32'd0);

    // Single chirp with latency check
    push_seq(0);
    @(negedge clk);
    trigger = 1'b1;
    @(posedge clk); #1;
    chk("busy at trigger edge", {31'd0, busy}, 32'd1);
    @(negedge clk);
    trigger = 1'b0;
    @(posedge clk); #1;
    chk("cs high at N+1", {31'd0, cs}, 32'd1);
    chk("sample_out at N+1", {20'd0, sample_out}, 32'h0C00);
    @(posedge clk); #1;
    chk("cs low at N+2", {31'd0, cs}, 32'd0);
    wait_idle(0, "chirp1");
    chk("chirp1 frames", frames[0], 32'd25);
    chk("chirp1 queue empty", q0.size(), 32'd0);

    // Retrigger during note 1, in the gap between frames
    push_seq(0);
    base = frames[0];
    pulse(0);
    n = 0;
    while (frames[0] < base + 10 && n < 3000) begin @(negedge clk); n++; end
    chk("retrig reach note1", {31'd0, (n < 3000)}, 32'd1);
    chk("retrig gap cs high", {31'd0, cs}, 32'd1);
    q0.delete();
    push_seq(0);
    pulse(0);
    wait_idle(0, "retrig");
    chk("retrig frames", frames[0] - base, 32'd35);
    chk("retrig queue empty", q0.size(), 32'd0);

    // Reset mid-frame at bit 7
    base = frames[0];
    pulse(0);
    n = 0;
    while (nbits[0] < 7 && n < 3000) begin @(negedge clk); n++; end
    chk("midframe cs low", {31'd0, cs}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset abort outputs", {busy, cs, sck}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("no frames after abort", frames[0] - base, 32'd0);
    chk("idle after abort", {busy, cs, sdi}, {1'b0, 1'b1, 1'b0});

    // Clamped half-period and saturated amplitude
    push_seq(1);
    pulse(1);
    wait_idle(1, "clamp");
    chk("clamp frames", frames[1], 32'd25);
    chk("clamp queue empty", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
